// File: rtl/button_event.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_event: turns a debounced button level into single-cycle short,    |
// | long and double press pulses, plus a registered "held" level.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module button_event #(
  parameter int CLK_FREQ      = 95_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic button_valid,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  localparam int PRESC_W = $clog2(CLK_FREQ);
  localparam int MS_MAX  = (LONG_PRESS_MS > DOUBLE_GAP_MS) ? LONG_PRESS_MS : DOUBLE_GAP_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_LONG_HELD = 3'd2,
    S_GAP       = 3'd3,
    S_PRESS2    = 3'd4
  } state_t;

  state_t             state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [MS_W-1:0]    ms_q;

  logic presc_wrap;
  logic long_done;
  logic gap_done;

  // Counters restart on entry to a state, so these fire on exactly the N-th / M-th edge in it.
  assign presc_wrap = (presc_q == PRESC_W'(CLK_FREQ - 1));
  assign long_done  = presc_wrap && (ms_q == MS_W'(LONG_PRESS_MS - 1));
  assign gap_done   = presc_wrap && (ms_q == MS_W'(DOUBLE_GAP_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      ms_q         <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;

      if (presc_wrap) begin
        presc_q <= '0;
        if (ms_q != '1) ms_q <= ms_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      // Every transition below also clears both counters (later NBA overrides the advance).
      case (state_q)
        S_IDLE: begin
          if (button_valid) begin
            state_q <= S_PRESS1;
            held    <= 1'b1;
            presc_q <= '0;
            ms_q    <= '0;
          end
        end
        S_PRESS1: begin
          if (!button_valid) begin
            state_q <= S_GAP;
            held    <= 1'b0;
            presc_q <= '0;
            ms_q    <= '0;
          end else if (long_done) begin
            state_q    <= S_LONG_HELD;
            long_press <= 1'b1;
            presc_q    <= '0;
            ms_q       <= '0;
          end
        end
        S_LONG_HELD: begin
          if (!button_valid) begin
            state_q <= S_IDLE;
            held    <= 1'b0;
            presc_q <= '0;
            ms_q    <= '0;
          end
        end
        S_GAP: begin
          if (button_valid) begin
            state_q      <= S_PRESS2;
            held         <= 1'b1;
            double_press <= 1'b1;
            presc_q      <= '0;
            ms_q         <= '0;
          end else if (gap_done) begin
            state_q     <= S_IDLE;
            short_press <= 1'b1;
            presc_q     <= '0;
            ms_q        <= '0;
          end
        end
        S_PRESS2: begin
          if (!button_valid) begin
            state_q <= S_IDLE;
            held    <= 1'b0;
            presc_q <= '0;
            ms_q    <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          held    <= 1'b0;
          presc_q <= '0;
          ms_q    <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_event: directed gestures with a queued-event scoreboard.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_button_event;

  localparam int K_RISE   = 0;
  localparam int K_FALL   = 1;
  localparam int K_SHORT  = 2;
  localparam int K_LONG   = 3;
  localparam int K_DOUBLE = 4;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_valid = 1'b0;
  logic short_press, long_press, double_press, held;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  logic prev_held = 1'b0;
  evt_t exp_q[$];

  button_event #(
    .CLK_FREQ     (10),
    .LONG_PRESS_MS(5),
    .DOUBLE_GAP_MS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_valid(button_valid),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:   return "held_rise";
      K_FALL:   return "held_fall";
      K_SHORT:  return "short_press";
      K_LONG:   return "long_press";
      K_DOUBLE: return "double_press";
      default:  return "unknown";
    endcase
  endfunction

  task automatic expect_evt(input int k, input int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int k);
    evt_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got %s at edge %0d, required nothing", kname(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        bad++;
        $display("FAIL event_order: got %s at edge %0d, required %s at edge %0d",
                 kname(k), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (held === 1'b1 && prev_held === 1'b0) check_evt(K_RISE);
      if (held === 1'b0 && prev_held === 1'b1) check_evt(K_FALL);
      if (short_press === 1'b1)  check_evt(K_SHORT);
      if (long_press === 1'b1)   check_evt(K_LONG);
      if (double_press === 1'b1) check_evt(K_DOUBLE);
      if ((32'(short_press) + 32'(long_press) + 32'(double_press)) > 1) begin
        total++;
        bad++;
        $display("FAIL exclusive: got s=%b l=%b d=%b at edge %0d, required at most one",
                 short_press, long_press, double_press, cyc);
      end
      prev_held = held;
    end
  end

  // Drives a new level; e is the edge that samples it.
  task automatic set_bv(input logic v, output int e);
    @(negedge clk);
    button_valid = v;
    e = cyc + 1;
  endtask

  task automatic hold(input int h);
    repeat (h - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r0;

    // Reset held with the button pressed: everything stays low.
    button_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({short_press, long_press, double_press, held} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_outputs: got s/l/d/h=%b, required 0000 (cycle %0d)",
                 {short_press, long_press, double_press, held}, i);
      end
    end
    rst = 1'b0;
    e0 = cyc + 1;
    mon_en = 1'b1;
    expect_evt(K_RISE, e0);
    hold(20);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    expect_evt(K_SHORT, r0 + 30);
    idle(60);

    // Short press, 20 cycles.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    hold(20);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    expect_evt(K_SHORT, r0 + 30);
    idle(60);

    // Long press, 120 cycles.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    expect_evt(K_LONG, e0 + 50);
    hold(120);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    idle(60);

    // Release sampled on the N-th edge wins over the long press.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    hold(50);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, e0 + 50);
    expect_evt(K_SHORT, e0 + 80);
    idle(60);

    // One cycle longer: long press only.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    expect_evt(K_LONG, e0 + 50);
    hold(51);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, e0 + 51);
    idle(60);

    // Double press with repress on the M-th gap edge.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    hold(10);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    hold(30);
    set_bv(1'b1, e0);
    expect_evt(K_RISE, r0 + 30);
    expect_evt(K_DOUBLE, r0 + 30);
    hold(10);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    idle(60);

    // Gap of 31 cycles: two separate short presses.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    hold(10);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    expect_evt(K_SHORT, r0 + 30);
    hold(31);
    set_bv(1'b1, e0);
    expect_evt(K_RISE, r0 + 31);
    hold(10);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    expect_evt(K_SHORT, r0 + 30);
    idle(60);

    // Reset while in the gap discards the gesture.
    set_bv(1'b1, e0);
    expect_evt(K_RISE, e0);
    hold(10);
    set_bv(1'b0, r0);
    expect_evt(K_FALL, r0);
    idle(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(60);

    while (exp_q.size() > 0) begin
      evt_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got nothing, required %s at edge %0d", kname(e.kind), e.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
